// File: rtl/conv_frame_sender_if.sv
// conv_frame_sender_if: valid/ready byte bus carrying matrix elements plus side-band size
interface conv_frame_sender_if #(parameter int DW = 8);
  logic [DW-1:0] tx_data;
  logic [7:0] tx_size;
  logic tx_valid;
  logic tx_last;
  logic tx_ready;
  modport master(output tx_data, tx_size, tx_valid, tx_last, input tx_ready);
  modport slave(input tx_data, tx_size, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/conv_frame_sender.sv
// conv_frame_sender: buffers an N x N element matrix and streams it row-major on a valid/ready bus
module conv_frame_sender #(
  parameter int MAX_N = 4,
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int SW = 3
)(
  input logic clk,
  input logic rst,
  input logic wr_en,
  input logic [AW-1:0] wr_addr,
  input logic [DW-1:0] wr_data,
  input logic start,
  input logic [SW-1:0] size_in,
  conv_frame_sender_if.master tx,
  output logic busy,
  output logic done,
  output logic err
);
  localparam int DEPTH = MAX_N * MAX_N;
  localparam int CW = AW > 2 * SW ? AW : 2 * SW;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] count, count_n, last_idx;
  logic [SW-1:0] n_reg, n_n;
  logic [2*SW-1:0] nn;
  logic err_n, size_ok, xfer, last;
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (wr_en && state == IDLE && {1'b0, wr_addr} < (AW+1)'(DEPTH)) mem[wr_addr] <= wr_data;
  // full-width square so n*n never truncates
  assign nn = {{SW{1'b0}}, n_reg} * {{SW{1'b0}}, n_reg};
  assign last_idx = CW'(nn) - CW'(1);
  assign last = state == SEND && count == last_idx;
  assign size_ok = size_in != '0 && size_in <= SW'(MAX_N);
  assign xfer = tx.tx_valid && tx.tx_ready;
  assign tx.tx_valid = state == SEND;
  assign tx.tx_last = last;
  assign tx.tx_data = state == SEND ? mem[count[AW-1:0]] : '0;
  assign tx.tx_size = busy ? 8'(n_reg) : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      count <= '0;
      n_reg <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      n_reg <= n_n;
      err <= err_n;
    end
  always_comb begin
    state_n = state;
    count_n = count;
    n_n = n_reg;
    err_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = size_ok ? SEND : IDLE;
        n_n = size_ok ? size_in : n_reg;
        count_n = size_ok ? '0 : count;
        err_n = !size_ok;
      end
      SEND: if (xfer) begin
        state_n = last ? DONE : SEND;
        count_n = last ? count : count + CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/conv_frame_sender.md
Name: conv_frame_sender

Overview:
- Transmit-side counterpart of the convolution engine's byte-wide input interface.
- Buffers an N x N matrix of 8-bit elements, written by a host through a simple write port.
- On a start command, streams the matrix in row-major order, one element per accepted beat, on a valid/ready byte bus. The matrix dimension is held alongside the data on a side-band size bus.
- Sits between the host/test controller and the engine's element/size inputs.

Parameters:
- MAX_N, 4, maximum matrix dimension; the buffer holds MAX_N*MAX_N elements.
- DW, 8, element width in bits.
- AW, 4, buffer address width; must satisfy 2**AW >= MAX_N*MAX_N.
- SW, 3, size field width; must satisfy 2**SW > MAX_N.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW  buffer write address, row-major index r*n+c.
- wr_data  in  DW  element to write.
- start  in  1  single-cycle start command.
- size_in  in  SW  matrix dimension n, sampled with start.
- tx_data  out  DW  current element.
- tx_size  out  8  latched n, zero-extended.
- tx_valid  out  1  tx_data is valid.
- tx_last  out  1  current beat is element n*n-1.
- tx_ready  in  1  downstream accepts the beat.
- busy  out  1  state is SEND or DONE.
- done  out  1  one-cycle pulse when the frame is complete.
- err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (async assert; release synchronous to clk):
  - state=IDLE, count=0, n_reg=0.
  - All outputs 0: tx_valid, tx_last, tx_data, tx_size, busy, done, err.
  - Buffer contents are not reset.
- Buffer writes:
  - On clk with wr_en=1, state=IDLE and wr_addr<MAX_N*MAX_N: mem[wr_addr]<=wr_data.
  - Writes are ignored in SEND or DONE, and for out-of-range addresses.
- FSM, state IDLE:
  - start=1 and 1<=size_in<=MAX_N: n_reg<=size_in, count<=0, go SEND.
  - start=1 with size_in=0 or size_in>MAX_N: err=1 for the next cycle, stay IDLE.
  - A write and a start in the same cycle: the write completes; SEND first outputs on the next cycle and sees the written value.
- FSM, state SEND:
  - tx_valid=1, tx_data=mem[count], tx_size=n_reg.
  - tx_last=1 when count==n_reg*n_reg-1. The product uses at least 2*SW bits and must not truncate.
  - Handshake: a beat transfers on a cycle with tx_valid&tx_ready.
  - Without a transfer, tx_data, tx_last and count hold.
  - On a transfer with tx_last=0: count<=count+1.
  - On a transfer with tx_last=1: go DONE.
  - start is ignored while busy; no err.
- FSM, state DONE:
  - Lasts one cycle; done=1, tx_valid=0, then go IDLE.
  - tx_size returns to 0 in IDLE.
- Output timing:
  - tx_valid rises the first cycle after the start cycle.
  - tx_valid never drops mid-frame except on reset.
- Throughput:
  - With tx_ready held 1, a frame is n*n consecutive beats.
  - done is asserted the cycle after the last beat.
  - The next start is accepted one cycle after done.
- Reset mid-frame: immediate abort to IDLE with all outputs 0. No done pulse. The buffer keeps its contents.
- Latency from start to the first beat is 1 cycle. Total frame time with no backpressure is n*n+1 cycles including DONE.

Test Plan:
1. Write mem[i]=i+1 for i=0..15, start size_in=4, tx_ready=1 → 16 beats carrying 1..16 on consecutive cycles; tx_last only on 16; tx_size=4 throughout; done pulse one cycle later; busy=0 after.
2. Same load, start size_in=2, tx_ready toggling 1,0,1,0 → 4 beats carrying 1,2,3,4; tx_data stable during ready=0 cycles; tx_last on 4; done after 8 cycles of SEND.
3. start with size_in=0, then start with size_in=5 → err pulses on each, tx_valid stays 0, busy stays 0.
4. start size_in=1 with mem[0]=0xA5 → single beat with tx_data=0xA5, tx_last=1; done follows.
5. During a size-3 frame, issue wr_en to addr 0 with data 0xFF and a second start → buffer unchanged (verified by replay), no err, frame completes normally.
6. Assert rst after the 5th beat of a size-4 frame → outputs 0 immediately, no done; restart delivers from element 0 with the buffer contents intact.
